// File: rtl/cpu_sequencer.sv
// Control sequencer for the simple RISC datapath: instruction register, field decode
// and a Moore FSM that steps the register file, A/B/C and status registers.
module cpu_sequencer #(
  parameter int IW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] in,
  input  logic          load,
  input  logic          s,
  output logic          w,
  output logic [2:0]    nsel,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    vsel,
  output logic [1:0]    ALUop,
  output logic [1:0]    shift,
  output logic [DW-1:0] sximm8,
  output logic [DW-1:0] sximm5,
  output logic          bad
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B, S_CALC, S_WB
  } state_t;

  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       bad;
  } ctrl_t;

  localparam logic [4:0] K_MOV_IMM = 5'b11010;
  localparam logic [4:0] K_MOV_REG = 5'b11000;
  localparam logic [4:0] K_ADD     = 5'b10100;
  localparam logic [4:0] K_CMP     = 5'b10101;
  localparam logic [4:0] K_AND     = 5'b10110;
  localparam logic [4:0] K_MVN     = 5'b10111;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] ir;
  logic [IW-1:0] ir_next;
  ctrl_t         ctrl;
  logic [2:0]    reg_sel;

  function automatic state_t next_state(state_t st, logic start, logic [IW-1:0] i);
    state_t n;
    n = S_WAIT;
    case (st)
      S_WAIT:   n = start ? S_DECODE : S_WAIT;
      S_DECODE: begin
        case (i[15:11])
          K_MOV_IMM:             n = S_WR_IMM;
          K_MOV_REG, K_MVN:      n = S_GET_B;
          K_ADD, K_CMP, K_AND:   n = S_GET_A;
          default:               n = S_WAIT;
        endcase
      end
      S_GET_A:  n = S_GET_B;
      S_GET_B:  n = S_CALC;
      S_CALC:   n = (i[15:11] == K_CMP) ? S_WAIT : S_WB;
      default:  n = S_WAIT;
    endcase
    return n;
  endfunction

  // Control word for a state; registered on entry so every output is a pure state function.
  function automatic ctrl_t ctrl_for(state_t st, logic [IW-1:0] i);
    ctrl_t c;
    c = '0;
    case (st)
      S_WAIT:   c.w = 1'b1;
      S_DECODE: c.bad = (next_state(S_DECODE, 1'b0, i) == S_WAIT);
      S_WR_IMM: begin
        c.nsel  = 3'b100;
        c.vsel  = 2'b01;
        c.write = 1'b1;
      end
      S_GET_A: begin
        c.nsel  = 3'b100;
        c.loada = 1'b1;
      end
      S_GET_B: begin
        c.nsel  = 3'b001;
        c.loadb = 1'b1;
      end
      S_CALC: begin
        if (i[15:11] == K_CMP) begin
          c.loads = 1'b1;
        end else begin
          c.loadc = 1'b1;
          c.asel  = (i[15:11] == K_MOV_REG) || (i[15:11] == K_MVN);
        end
      end
      S_WB: begin
        c.nsel  = 3'b010;
        c.write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // A load coinciding with the start strobe supplies the instruction that gets executed.
  assign ir_next    = (state == S_WAIT && load) ? in : ir;
  assign state_next = next_state(state, s, ir_next);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
      ctrl  <= ctrl_for(S_WAIT, {IW{1'b0}});
    end else begin
      state <= state_next;
      ir    <= ir_next;
      ctrl  <= ctrl_for(state_next, ir_next);
    end
  end

  always_comb begin
    reg_sel = 3'b000;
    case (ctrl.nsel)
      3'b100:  reg_sel = ir[10:8];
      3'b010:  reg_sel = ir[7:5];
      3'b001:  reg_sel = ir[2:0];
      default: reg_sel = 3'b000;
    endcase
  end

  // Reset masks the strobes immediately so an aborted instruction never writes back.
  assign write    = ctrl.write & ~reset;
  assign loada    = ctrl.loada & ~reset;
  assign loadb    = ctrl.loadb & ~reset;
  assign loadc    = ctrl.loadc & ~reset;
  assign loads    = ctrl.loads & ~reset;
  assign bad      = ctrl.bad & ~reset;
  assign w        = ctrl.w;
  assign nsel     = ctrl.nsel;
  assign asel     = ctrl.asel;
  assign bsel     = ctrl.bsel;
  assign vsel     = ctrl.vsel;
  assign readnum  = reg_sel;
  assign writenum = reg_sel;
  assign ALUop    = ir[12:11];
  assign shift    = ir[4:3];
  assign sximm8   = {{(DW-8){ir[7]}}, ir[7:0]};
  assign sximm5   = {{(DW-5){ir[4]}}, ir[4:0]};

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues the expected strobe events of each
// instruction, a negedge monitor pops and compares every cycle in which a strobe fires.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  nsel, readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel, bad;
  logic [1:0]  vsel, ALUop, shift;
  logic [15:0] sximm8, sximm5;

  typedef struct packed {
    logic [5:0]  strobes;
    logic [2:0]  nsel;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  vsel;
    logic        asel;
    logic        bsel;
    logic [1:0]  aluop;
    logic [1:0]  shift;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
  } ev_t;

  int  errors = 0;
  int  checks = 0;
  ev_t exp_q[$];
  int  lat[7] = '{3, 5, 6, 5, 6, 5, 2};
  logic [4:0] legal_keys[6] = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111};

  cpu_sequencer #(.IW(16), .DW(16)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
    .nsel(nsel), .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .ALUop(ALUop), .shift(shift),
    .sximm8(sximm8), .sximm5(sximm5), .bad(bad)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  // Instruction class from the opcode table: 0 MOV-imm, 1 MOV-reg, 2 ADD, 3 CMP, 4 AND, 5 MVN, 6 illegal.
  function automatic int classify(logic [15:0] i);
    case (i[15:11])
      5'b11010: return 0;
      5'b11000: return 1;
      5'b10100: return 2;
      5'b10101: return 3;
      5'b10110: return 4;
      5'b10111: return 5;
      default:  return 6;
    endcase
  endfunction

  function automatic ev_t ev(logic [15:0] i, logic [5:0] strobes, logic [2:0] nsel_v,
                             logic [2:0] r, logic [1:0] vsel_v, logic asel_v);
    ev_t e;
    int v8, v5;
    v8 = int'(i[7:0]);
    if (v8 >= 128) v8 -= 256;
    v5 = int'(i[4:0]);
    if (v5 >= 16) v5 -= 32;
    e = '0;
    e.strobes  = strobes;
    e.nsel     = nsel_v;
    e.readnum  = r;
    e.writenum = r;
    e.vsel     = vsel_v;
    e.asel     = asel_v;
    e.aluop    = i[12:11];
    e.shift    = i[4:3];
    e.sximm8   = v8[15:0];
    e.sximm5   = v5[15:0];
    return e;
  endfunction

  function automatic ev_t observe();
    ev_t o;
    o.strobes  = {write, loada, loadb, loadc, loads, bad};
    o.nsel     = nsel;
    o.readnum  = readnum;
    o.writenum = writenum;
    o.vsel     = vsel;
    o.asel     = asel;
    o.bsel     = bsel;
    o.aluop    = ALUop;
    o.shift    = shift;
    o.sximm8   = sximm8;
    o.sximm5   = sximm5;
    return o;
  endfunction

  // Reference: the datapath steps each instruction class must perform, in order.
  task automatic push_expected(input logic [15:0] i);
    logic [2:0] rn, rd, rm;
    rn = i[10:8];
    rd = i[7:5];
    rm = i[2:0];
    case (classify(i))
      0: exp_q.push_back(ev(i, 6'b100000, 3'b100, rn, 2'b01, 1'b0));
      1, 5: begin
        exp_q.push_back(ev(i, 6'b001000, 3'b001, rm, 2'b00, 1'b0));
        exp_q.push_back(ev(i, 6'b000100, 3'b000, 3'd0, 2'b00, 1'b1));
        exp_q.push_back(ev(i, 6'b100000, 3'b010, rd, 2'b00, 1'b0));
      end
      2, 4: begin
        exp_q.push_back(ev(i, 6'b010000, 3'b100, rn, 2'b00, 1'b0));
        exp_q.push_back(ev(i, 6'b001000, 3'b001, rm, 2'b00, 1'b0));
        exp_q.push_back(ev(i, 6'b000100, 3'b000, 3'd0, 2'b00, 1'b0));
        exp_q.push_back(ev(i, 6'b100000, 3'b010, rd, 2'b00, 1'b0));
      end
      3: begin
        exp_q.push_back(ev(i, 6'b010000, 3'b100, rn, 2'b00, 1'b0));
        exp_q.push_back(ev(i, 6'b001000, 3'b001, rm, 2'b00, 1'b0));
        exp_q.push_back(ev(i, 6'b000010, 3'b000, 3'd0, 2'b00, 1'b0));
      end
      default: exp_q.push_back(ev(i, 6'b000001, 3'b000, 3'd0, 2'b00, 1'b0));
    endcase
  endtask

  // noise: 0 quiet, 1 random load/in while busy, 2 load=1 with in=0xD007 while busy.
  task automatic applyStimulus(input logic [15:0] instr, input bit same_edge, input int noise);
    int edges;
    if (!same_edge) begin
      in = instr;
      load = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      in = 16'($urandom);
    end else begin
      in = instr;
      load = 1'b1;
    end
    s = 1'b1;
    push_expected(instr);
    @(posedge clk);
    #1;
    s = 1'b0;
    load = 1'b0;
    edges = 1;
    while (w !== 1'b1 && edges < 20) begin
      if (noise == 1) begin
        load = 1'($urandom);
        in = 16'($urandom);
      end else if (noise == 2) begin
        load = 1'b1;
        in = 16'hD007;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    load = 1'b0;
    checkOutput($sformatf("latency_%h", instr), 64'(edges), 64'(lat[classify(instr)]));
  endtask

  always @(negedge clk) begin
    ev_t o;
    ev_t e;
    o = observe();
    if (o.strobes != 6'b0) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_strobe", 64'(o), 64'(0));
      end else begin
        e = exp_q.pop_front();
        checkOutput("event", 64'(o), 64'(e));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] instr;
    reset = 1'b1;
    in = 16'h0;
    load = 1'b0;
    s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_w", 64'(w), 64'(1));
    checkOutput("reset_strobes", 64'({write, loada, loadb, loadc, loads, bad}), 64'(0));
    checkOutput("reset_sximm8", 64'(sximm8), 64'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(16'hD007, 1'b1, 0);
    applyStimulus(16'hD1FE, 1'b0, 0);
    applyStimulus(16'hA148, 1'b0, 0);
    applyStimulus(16'hA900, 1'b1, 0);
    applyStimulus(16'hB864, 1'b0, 0);
    applyStimulus(16'hC0B6, 1'b1, 0);
    applyStimulus(16'hE000, 1'b0, 0);
    applyStimulus(16'hA148, 1'b1, 2);

    // Abort ADD during GET_B: only the GET_A strobe may ever appear.
    in = 16'hA148;
    load = 1'b1;
    s = 1'b1;
    exp_q.push_back(ev(16'hA148, 6'b010000, 3'b100, 3'd1, 2'b00, 1'b0));
    repeat (3) begin
      @(posedge clk);
      #1;
      load = 1'b0;
      s = 1'b0;
    end
    reset = 1'b1;
    #1;
    checkOutput("abort_strobes", 64'({write, loada, loadb, loadc, loads, bad}), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort_w", 64'(w), 64'(1));
    checkOutput("abort_ir", 64'({sximm8, ALUop, shift}), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_pending", 64'(exp_q.size()), 64'(0));

    for (int k = 0; k < 40; k++) begin
      instr = 16'($urandom);
      if ($urandom_range(3) != 0) instr[15:11] = legal_keys[$urandom_range(5)];
      applyStimulus(instr, 1'($urandom), int'($urandom_range(1)));
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
